// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and the kernel word-to-tap mapping used by
// the tile loader and the downstream compute units.
package cnn_pkg;

    localparam int DATA_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int NUM_WORDS   = 14;
    localparam int IFMAP_WORDS = 8;
    localparam int KERNEL_TAPS = 9;
    localparam int TILE_BYTES  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Kernel word kw (0..5 = load words 8..13) writes this tap from bits [15:8].
    function automatic logic [3:0] kword_hi_tap(input logic [2:0] kw);
        case (kw)
            3'd0:    return 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd3;
            3'd3:    return 4'd5;
            3'd4:    return 4'd6;
            3'd5:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Even kernel words also carry the next tap in bits [7:0].
    function automatic logic kword_has_lo(input logic [2:0] kw);
        return ~kw[0];
    endfunction

endpackage

// File: rtl/cnn_kernel_unpack.sv
// Decodes one load word into kernel-bus byte writes and zero flags, indexed in
// bus order (slot 8 = tap 0) so the results drop straight onto kernel/mask.
module cnn_kernel_unpack
    import cnn_pkg::*;
(
    input  logic                                    en,
    input  logic [3:0]                              word_idx,
    input  logic [15:0]                             word,
    output logic [KERNEL_TAPS-1:0]                  bus_we,
    output logic [KERNEL_TAPS-1:0][BYTE_W-1:0]      bus_byte_we,
    output logic [KERNEL_TAPS-1:0][BYTE_W-1:0]      bus_byte,
    output logic [KERNEL_TAPS-1:0]                  bus_zero
);

    logic [2:0] kw;
    logic [3:0] hi_slot;
    logic [3:0] lo_slot;

    always_comb begin
        bus_we      = '0;
        bus_byte_we = '0;
        bus_byte    = '0;
        bus_zero    = '0;
        // Kernel words 8..13 have their kernel-relative index in the low 3 bits.
        kw      = word_idx[2:0];
        hi_slot = 4'd8 - kword_hi_tap(kw);
        lo_slot = hi_slot - 4'd1;
        if (en && word_idx >= 4'(IFMAP_WORDS) && word_idx < 4'(NUM_WORDS)) begin
            bus_we[hi_slot]      = 1'b1;
            bus_byte_we[hi_slot] = '1;
            bus_byte[hi_slot]    = word[15:8];
            bus_zero[hi_slot]    = (word[15:8] == 8'h00);
            if (kword_has_lo(kw)) begin
                bus_we[lo_slot]      = 1'b1;
                bus_byte_we[lo_slot] = '1;
                bus_byte[lo_slot]    = word[7:0];
                bus_zero[lo_slot]    = (word[7:0] == 8'h00);
            end
        end
    end

endmodule

// File: rtl/cnn_tile_loader.sv
// Collects 14 load words into a 4x4 ifmap tile and 3x3 kernel, then offers the
// tile downstream with a valid/ready handshake.
//
// state    | meaning
// ST_EMPTY | no words held, fill_count = 0
// ST_FILL  | 1..13 words held, next load goes to word fill_count
// ST_FULL  | complete tile presented, data frozen until tile_ready
module cnn_tile_loader
    import cnn_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_en,
    input  logic [DATA_W-1:0]                 load_data,
    input  logic                              clear,
    input  logic                              tile_ready,
    output logic                              tile_valid,
    output logic [TILE_BYTES*BYTE_W-1:0]      ifmap,
    output logic [KERNEL_TAPS*BYTE_W-1:0]     kernel,
    output logic [KERNEL_TAPS-1:0]            kernel_zero_mask,
    output logic [3:0]                        fill_count,
    output logic                              load_drop
);

    state_t                                 state_q, state_d;
    logic [3:0]                             fill_q, fill_d;
    logic                                   drop_q, drop_d;
    logic [TILE_BYTES-1:0][BYTE_W-1:0]      ifmap_q, ifmap_d;
    logic [KERNEL_TAPS-1:0][BYTE_W-1:0]     kernel_q, kernel_d;
    logic [KERNEL_TAPS-1:0]                 mask_q, mask_d;

    logic                                   wr_en;
    logic [3:0]                             wr_idx;
    logic [15:0]                            word;
    logic [3:0]                             if_slot_hi;
    logic [3:0]                             if_slot_lo;
    logic [KERNEL_TAPS-1:0]                 bus_we;
    logic [KERNEL_TAPS-1:0][BYTE_W-1:0]     bus_byte_we;
    logic [KERNEL_TAPS-1:0][BYTE_W-1:0]     bus_byte;
    logic [KERNEL_TAPS-1:0]                 bus_zero;
    logic                                   unused_load_hi;

    assign word           = load_data[15:0];
    assign unused_load_hi = ^load_data[DATA_W-1:16];

    cnn_kernel_unpack u_unpack (
        .en          (wr_en),
        .word_idx    (wr_idx),
        .word        (word),
        .bus_we      (bus_we),
        .bus_byte_we (bus_byte_we),
        .bus_byte    (bus_byte),
        .bus_zero    (bus_zero)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        drop_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = fill_q;
        case (state_q)
            ST_EMPTY: begin
                if (load_en) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    fill_d  = 4'd1;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (load_en) begin
                    wr_en  = 1'b1;
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'(NUM_WORDS - 1)) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (tile_ready) begin
                    // A load in the handshake cycle starts the next tile.
                    wr_en   = load_en;
                    wr_idx  = 4'd0;
                    fill_d  = load_en ? 4'd1 : 4'd0;
                    state_d = load_en ? ST_FILL : ST_EMPTY;
                end else if (load_en) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                fill_d  = 4'd0;
            end
        endcase
        if (clear) begin
            state_d = ST_EMPTY;
            fill_d  = 4'd0;
            drop_d  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_comb begin
        ifmap_d    = ifmap_q;
        if_slot_hi = 4'd15 - {wr_idx[2:0], 1'b0};
        if_slot_lo = if_slot_hi - 4'd1;
        if (wr_en && wr_idx < 4'(IFMAP_WORDS)) begin
            ifmap_d[if_slot_hi] = word[15:8];
            ifmap_d[if_slot_lo] = word[7:0];
        end
        kernel_d = (kernel_q & ~bus_byte_we) | (bus_byte & bus_byte_we);
        mask_d   = (mask_q & ~bus_we) | (bus_zero & bus_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            fill_q   <= 4'd0;
            drop_q   <= 1'b0;
            ifmap_q  <= '0;
            kernel_q <= '0;
            mask_q   <= '1;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            drop_q   <= drop_d;
            ifmap_q  <= ifmap_d;
            kernel_q <= kernel_d;
            mask_q   <= mask_d;
        end
    end

    assign tile_valid       = (state_q == ST_FULL);
    assign ifmap            = ifmap_q;
    assign kernel           = kernel_q;
    assign kernel_zero_mask = mask_q;
    assign fill_count       = fill_q;
    assign load_drop        = drop_q;

endmodule
